// File: rtl/axis_pkg.sv
// Shared AXI-Stream sample type for the FFT datapath.
package axis_pkg;

  typedef logic [15:0] sample_t;

endpackage

// File: rtl/axis_pkt_framer.sv
// AXI-Stream packet framer: cuts an unframed sample stream into packets of a
// runtime-programmable length, tagging SOP on TUSER and EOP on TLAST, with a
// registered two-entry output stage so in_tready never depends on out_tready.
module axis_pkt_framer
  import axis_pkg::*;
#(
  parameter int unsigned  MAX_PACK_SIZE = 8192,
  parameter int unsigned  BUS_NUM       = 2,
  parameter int unsigned  PKT_CNT_W     = 16,
  localparam int unsigned CNT_W         = $clog2(MAX_PACK_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CNT_W-1:0]      pack_size,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  sample_t [BUS_NUM-1:0] in_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic                  out_tuser,
  output sample_t [BUS_NUM-1:0] out_tdata,
  output logic                  busy,
  output logic [PKT_CNT_W-1:0]  pkt_cnt,
  output logic                  cfg_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef struct packed {
    sample_t [BUS_NUM-1:0] data;
    logic                  last;
    logic                  user;
  } beat_t;

  localparam logic [CNT_W-1:0] MaxSize = CNT_W'(MAX_PACK_SIZE);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] size_r;

  logic  skid_valid;
  beat_t skid_beat;

  logic  accept;
  logic  out_fire;
  logic  size_ok;
  logic  last_beat;
  logic  skid_valid_nxt;
  beat_t in_beat;

  assign accept    = in_tvalid & in_tready;
  assign out_fire  = out_tvalid & out_tready;
  assign size_ok   = (pack_size != '0) && (pack_size <= MaxSize);
  assign last_beat = (cnt == size_r - CNT_W'(1));
  assign in_beat   = {in_tdata, last_beat, (cnt == '0)};

  // Skid occupancy after this edge; lets in_tready be computed as a register.
  // A full skid always drains into the output register when out_tready is high,
  // and only fills when the output register is full and stalled.
  assign skid_valid_nxt = skid_valid ? ~out_tready : (accept & out_tvalid & ~out_tready);

  assign busy = (state == StRun) | out_tvalid | skid_valid;

  // Framing FSM: latches the packet length at boundaries, counts beats, owns in_tready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      size_r    <= '0;
      cfg_err   <= 1'b0;
      in_tready <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          in_tready <= 1'b0;
          if (en) begin
            if (size_ok) begin
              size_r    <= pack_size;
              cfg_err   <= 1'b0;
              cnt       <= '0;
              state     <= StRun;
              in_tready <= ~skid_valid_nxt;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        StRun: begin
          in_tready <= ~skid_valid_nxt;
          if (accept) begin
            if (last_beat) begin
              cnt <= '0;
              // Packet boundary: the only place en and pack_size take effect.
              if (en && size_ok) begin
                size_r <= pack_size;
              end else begin
                state     <= StIdle;
                in_tready <= 1'b0;
                if (en) begin
                  cfg_err <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state     <= StIdle;
          in_tready <= 1'b0;
        end
      endcase
    end
  end

  // Output register plus skid register; skid contents always leave first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tuser  <= 1'b0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else if (!out_tvalid || out_tready) begin
      if (skid_valid) begin
        out_tvalid <= 1'b1;
        out_tdata  <= skid_beat.data;
        out_tlast  <= skid_beat.last;
        out_tuser  <= skid_beat.user;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_tvalid <= 1'b1;
        out_tdata  <= in_beat.data;
        out_tlast  <= in_beat.last;
        out_tuser  <= in_beat.user;
      end else begin
        out_tvalid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_beat  <= in_beat;
    end
  end

  // Completed-packet counter, counted at the output handshake of each EOP beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (out_fire && out_tlast) begin
      pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Self-checking bench for axis_pkt_framer: directed scenarios plus a randomized
// handshake run, all scored against a packet-level reference model.
module tb_axis_pkt_framer;
  import axis_pkg::*;

  localparam int unsigned MaxPackSize = 8192;
  localparam int unsigned BusNum      = 2;
  localparam int unsigned PktCntW     = 16;
  localparam int unsigned CntW        = $clog2(MaxPackSize + 1);

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [CntW-1:0]      pack_size;
  logic                 in_tvalid;
  logic                 in_tready;
  sample_t [BusNum-1:0] in_tdata;
  logic                 out_tvalid;
  logic                 out_tready;
  logic                 out_tlast;
  logic                 out_tuser;
  sample_t [BusNum-1:0] out_tdata;
  logic                 busy;
  logic [PktCntW-1:0]   pkt_cnt;
  logic                 cfg_err;

  axis_pkt_framer #(
    .MAX_PACK_SIZE(MaxPackSize),
    .BUS_NUM      (BusNum),
    .PKT_CNT_W    (PktCntW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pack_size (pack_size),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tdata  (in_tdata),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tlast (out_tlast),
    .out_tuser (out_tuser),
    .out_tdata (out_tdata),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [CntW-1:0] s);
    return (s != 0) && (s <= MaxPackSize);
  endfunction

  // Reference model: packet position and length, plus the expected output beats.
  bit              m_run;
  logic [CntW-1:0] m_size;
  int              m_pos;
  bit              m_err;
  logic [15:0]     m_pkt;
  logic [33:0]     exp_q[$];
  int              n_acc;
  int              n_out;
  bit              last_acc;
  bit              hold_pend;
  logic [33:0]     held;
  bit              rand_mode;

  // Monitor: observes both handshakes between edges and advances the model.
  initial begin
    logic [33:0] obs;
    logic [33:0] exp_b;
    bit          acc;
    n_acc = 0;
    n_out = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_run     = 1'b0;
        m_size    = '0;
        m_pos     = 0;
        m_err     = 1'b0;
        m_pkt     = '0;
        last_acc  = 1'b0;
        hold_pend = 1'b0;
        exp_q.delete();
      end else begin
        obs = {out_tdata, out_tlast, out_tuser};
        check_eq("out_tvalid", out_tvalid, exp_q.size() != 0);
        check_eq("busy", busy, m_run || (exp_q.size() != 0));
        check_eq("pkt_cnt", pkt_cnt, m_pkt);
        check_eq("cfg_err", cfg_err, m_err);
        if (!m_run) check_eq("tready_idle", in_tready, 1'b0);
        if (hold_pend) check_eq("stall_hold", {out_tvalid, obs}, {1'b1, held});
        hold_pend = 1'b0;
        if (out_tvalid) begin
          if (out_tready) begin
            check_eq("q_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              exp_b = exp_q.pop_front();
              check_eq("beat", obs, exp_b);
              if (exp_b[1]) m_pkt++;
            end
            n_out++;
          end else begin
            hold_pend = 1'b1;
            held      = obs;
          end
        end
        acc      = in_tvalid && in_tready;
        last_acc = acc;
        if (acc) begin
          n_acc++;
          check_eq("acc_in_run", m_run, 1'b1);
        end
        if (!m_run) begin
          if (en) begin
            if (legal(pack_size)) begin
              m_run  = 1'b1;
              m_size = pack_size;
              m_pos  = 0;
              m_err  = 1'b0;
            end else begin
              m_err = 1'b1;
            end
          end
        end else if (acc) begin
          exp_q.push_back({in_tdata, (m_pos == int'(m_size) - 1), (m_pos == 0)});
          if (m_pos == int'(m_size) - 1) begin
            m_pos = 0;
            if (en && legal(pack_size)) begin
              m_size = pack_size;
            end else begin
              m_run = 1'b0;
              if (en) m_err = 1'b1;
            end
          end else begin
            m_pos++;
          end
        end
      end
    end
  end

  // One clock of stimulus; a pending unaccepted beat keeps its data and valid.
  task automatic step();
    @(posedge clk);
    #1;
    if (!(in_tvalid && !last_acc)) begin
      in_tdata = $urandom;
      if (rand_mode) in_tvalid = ($urandom_range(0, 1) == 1);
    end
    if (rand_mode) out_tready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic wait_acc(input int target, input int max_cycles);
    int guard = 0;
    while (n_acc < target && guard < max_cycles) begin
      step();
      guard++;
    end
    check_eq("acc_reached", n_acc >= target, 1'b1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int guard = 0;
    while (busy && guard < max_cycles) begin
      step();
      guard++;
    end
    check_eq("drained", busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_in_tready", in_tready, 1'b0);
    check_eq("rst_out_tvalid", out_tvalid, 1'b0);
    check_eq("rst_out_tlast", out_tlast, 1'b0);
    check_eq("rst_out_tuser", out_tuser, 1'b0);
    check_eq("rst_out_tdata", out_tdata, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_pkt_cnt", pkt_cnt, 16'h0);
    check_eq("rst_cfg_err", cfg_err, 1'b0);
  endtask

  // Asynchronous reset pulse asserted mid-cycle, released just after an edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int base;
    int out_base;
    rst_n      = 1'b0;
    en         = 1'b0;
    pack_size  = '0;
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
    in_tdata   = '0;
    rand_mode  = 1'b0;
    #12;
    check_reset_outputs();
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back 4-beat packets at full rate.
    pack_size  = 14'd4;
    in_tvalid  = 1'b1;
    out_tready = 1'b1;
    en         = 1'b1;
    out_base   = n_out;
    cyc        = 0;
    do begin
      step();
      cyc++;
    end while (!out_tvalid && cyc < 10);
    check_eq("first_valid_lat", cyc, 2);
    for (int i = 1; i < 12; i++) begin
      step();
      check_eq("no_bubble", out_tvalid, 1'b1);
      if (i == 8) en = 1'b0;
    end
    wait_idle(50);
    check_eq("t1_pkt_cnt", pkt_cnt, 16'd3);
    check_eq("t1_beats", n_out - out_base, 12);
    check_eq("t1_idle_tready", in_tready, 1'b0);

    // en dropped mid-packet: packet still completes.
    pack_size = 14'd8;
    en        = 1'b1;
    base      = n_acc;
    out_base  = n_out;
    wait_acc(base + 3, 50);
    en = 1'b0;
    wait_idle(50);
    check_eq("t2_beats", n_out - out_base, 8);
    check_eq("t2_pkt_cnt", pkt_cnt, 16'd4);
    check_eq("t2_idle_tready", in_tready, 1'b0);

    // pack_size change mid-packet only affects the next packet.
    pack_size = 14'd5;
    en        = 1'b1;
    base      = n_acc;
    out_base  = n_out;
    wait_acc(base + 2, 50);
    pack_size = 14'd3;
    wait_acc(base + 6, 50);
    en = 1'b0;
    wait_idle(50);
    check_eq("t3_beats", n_out - out_base, 8);
    check_eq("t3_pkt_cnt", pkt_cnt, 16'd6);

    // Illegal size holds the framer idle with cfg_err, then recovers.
    pack_size = '0;
    en        = 1'b1;
    repeat (5) step();
    check_eq("t4_cfg_err_set", cfg_err, 1'b1);
    check_eq("t4_tready_low", in_tready, 1'b0);
    pack_size = 14'(MaxPackSize + 1);
    step();
    check_eq("t4_cfg_err_big", cfg_err, 1'b1);
    pack_size = 14'd2;
    base      = n_acc;
    out_base  = n_out;
    step();
    check_eq("t4_cfg_err_clr", cfg_err, 1'b0);
    wait_acc(base + 5, 50);
    en = 1'b0;
    wait_idle(50);
    check_eq("t4_beats", n_out - out_base, 6);
    check_eq("t4_pkt_cnt", pkt_cnt, 16'd9);

    // Random valid/ready with 6-beat packets.
    do_reset();
    pack_size = 14'd6;
    en        = 1'b1;
    rand_mode = 1'b1;
    base      = n_acc;
    out_base  = n_out;
    wait_acc(base + 991, 20000);
    en = 1'b0;
    wait_idle(2000);
    rand_mode  = 1'b0;
    in_tvalid  = 1'b0;
    out_tready = 1'b1;
    step();
    check_eq("t5_acc", n_acc - base, 996);
    check_eq("t5_beats", n_out - out_base, 996);
    check_eq("t5_pkt_cnt", pkt_cnt, 16'd166);

    // Single-beat packets, then reset mid-stream.
    pack_size = 14'd1;
    in_tvalid = 1'b1;
    en        = 1'b1;
    base      = n_acc;
    wait_acc(base + 10, 50);
    pack_size = 14'd3;
    do_reset();
    base     = n_acc;
    out_base = n_out;
    wait_acc(base + 7, 50);
    en = 1'b0;
    wait_idle(50);
    check_eq("t6_beats", n_out - out_base, 9);
    check_eq("t6_pkt_cnt", pkt_cnt, 16'd3);
    check_eq("q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
